lightbike_key_decoder: RTL and testbench

Converts the raw PS/2 set-2 scan-code stream from the keyboard receiver into game commands for the lightbike controller: per-player heading registers, a single-cycle start pulse and a single-cycle escape pulse. It sits between the keyboard/pulse-generator pair (upstream) and the game state machine (downstream). It handles E0/F0 prefixes, suppresses typematic repeats of the start and escape keys, and rejects 180° reversals against the direction the bike last actually moved.

---
 rtl/lightbike_key_decoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_lightbike_key_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lightbike_key_decoder.sv
// PS/2 set-2 scan-code decoder for the lightbike game.
// Emits per-player headings, start/escape pulses and the last make code.
module lightbike_key_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       move_tick,
  input  logic       game_idle,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       start_pulse,
  output logic       esc_pulse,
  output logic [7:0] last_code
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;

  localparam logic [7:0] K_E0  = 8'hE0;
  localparam logic [7:0] K_F0  = 8'hF0;
  localparam logic [7:0] K_SPC = 8'h29;
  localparam logic [7:0] K_ESC = 8'h76;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;

  logic            w_make_n;
  logic            w_make_e;
  logic            w_brk_n;

  logic            w_p1_req_v;
  logic [1:0]      w_p1_req;
  logic            w_p2_req_v;
  logic [1:0]      w_p2_req;
  logic            w_spc_mk;
  logic            w_spc_bk;
  logic            w_esc_mk;
  logic            w_esc_bk;

  logic [1:0]      r_p1_dir;
  logic [1:0]      r_p2_dir;
  logic [1:0]      r_moved1;
  logic [1:0]      r_moved2;
  logic            r_spc_held;
  logic            r_esc_held;
  logic            r_start;
  logic            r_esc;
  logic [7:0]      r_last;

  logic [1:0]      w_eff1;
  logic [1:0]      w_eff2;
  logic            w_ok1;
  logic            w_ok2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // A byte always clears the timeout; otherwise it runs only mid-prefix.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_make_n   = 1'b0;
    w_make_e   = 1'b0;
    w_brk_n    = 1'b0;
    if (scan_valid) begin
      w_cnt_nx = '0;
      unique case (r_state)
        S_IDLE: begin
          if (scan_code == K_E0) begin
            w_state_nx = S_EXT;
          end else if (scan_code == K_F0) begin
            w_state_nx = S_BRK;
          end else begin
            w_make_n = 1'b1;
          end
        end
        S_EXT: begin
          if (scan_code == K_F0) begin
            w_state_nx = S_EXT_BRK;
          end else if (scan_code != K_E0) begin
            w_make_e   = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        S_BRK: begin
          w_brk_n    = 1'b1;
          w_state_nx = S_IDLE;
        end
        S_EXT_BRK: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_cnt == TMAX) begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end else begin
        w_cnt_nx = r_cnt + CW'(1);
      end
    end else begin
      w_cnt_nx = '0;
    end
  end

  always_comb begin
    w_p1_req_v = 1'b0;
    w_p1_req   = UP;
    w_p2_req_v = 1'b0;
    w_p2_req   = UP;
    w_spc_mk   = 1'b0;
    w_esc_mk   = 1'b0;
    w_spc_bk   = w_brk_n && (scan_code == K_SPC);
    w_esc_bk   = w_brk_n && (scan_code == K_ESC);
    if (w_make_n) begin
      case (scan_code)
        8'h1D: begin
          w_p1_req_v = 1'b1;
          w_p1_req   = UP;
        end
        8'h1B: begin
          w_p1_req_v = 1'b1;
          w_p1_req   = DOWN;
        end
        8'h1C: begin
          w_p1_req_v = 1'b1;
          w_p1_req   = LEFT;
        end
        8'h23: begin
          w_p1_req_v = 1'b1;
          w_p1_req   = RIGHT;
        end
        K_SPC:   w_spc_mk = 1'b1;
        K_ESC:   w_esc_mk = 1'b1;
        default: ;
      endcase
    end
    if (w_make_e) begin
      case (scan_code)
        8'h75: begin
          w_p2_req_v = 1'b1;
          w_p2_req   = UP;
        end
        8'h72: begin
          w_p2_req_v = 1'b1;
          w_p2_req   = DOWN;
        end
        8'h6B: begin
          w_p2_req_v = 1'b1;
          w_p2_req   = LEFT;
        end
        8'h74: begin
          w_p2_req_v = 1'b1;
          w_p2_req   = RIGHT;
        end
        default: ;
      endcase
    end
  end

  // A tick this cycle means the bike is about to move along p_dir.
  assign w_eff1 = move_tick ? r_p1_dir : r_moved1;
  assign w_eff2 = move_tick ? r_p2_dir : r_moved2;
  assign w_ok1  = w_p1_req_v && (w_p1_req != (w_eff1 ^ 2'b10));
  assign w_ok2  = w_p2_req_v && (w_p2_req != (w_eff2 ^ 2'b10));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_p1_dir   <= RIGHT;
      r_p2_dir   <= LEFT;
      r_moved1   <= RIGHT;
      r_moved2   <= LEFT;
      r_spc_held <= 1'b0;
      r_esc_held <= 1'b0;
      r_start    <= 1'b0;
      r_esc      <= 1'b0;
      r_last     <= 8'h00;
    end else begin
      r_start <= w_spc_mk && !r_spc_held;
      r_esc   <= w_esc_mk && !r_esc_held;
      if (w_spc_mk) begin
        r_spc_held <= 1'b1;
      end else if (w_spc_bk) begin
        r_spc_held <= 1'b0;
      end
      if (w_esc_mk) begin
        r_esc_held <= 1'b1;
      end else if (w_esc_bk) begin
        r_esc_held <= 1'b0;
      end
      if (w_make_n || w_make_e) begin
        r_last <= scan_code;
      end
      if (game_idle) begin
        r_p1_dir <= RIGHT;
        r_moved1 <= RIGHT;
        r_p2_dir <= LEFT;
        r_moved2 <= LEFT;
      end else begin
        if (move_tick) begin
          r_moved1 <= r_p1_dir;
          r_moved2 <= r_p2_dir;
        end
        if (w_ok1) begin
          r_p1_dir <= w_p1_req;
        end
        if (w_ok2) begin
          r_p2_dir <= w_p2_req;
        end
      end
    end
  end

  assign p1_dir      = r_p1_dir;
  assign p2_dir      = r_p2_dir;
  assign start_pulse = r_start;
  assign esc_pulse   = r_esc;
  assign last_code   = r_last;

endmodule

// File: tb/tb_lightbike_key_decoder.sv
// Directed bench for lightbike_key_decoder.
// Timeout is shortened to 1000 cycles to keep the run brief.
module tb_lightbike_key_decoder;

  logic       clk;
  logic       reset_n;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       move_tick;
  logic       game_idle;
  logic [1:0] p1_dir;
  logic [1:0] p2_dir;
  logic       start_pulse;
  logic       esc_pulse;
  logic [7:0] last_code;

  int n_chk;
  int n_fail;
  int n_start;
  int n_esc;
  int base;

  lightbike_key_decoder #(
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .move_tick  (move_tick),
    .game_idle  (game_idle),
    .p1_dir     (p1_dir),
    .p2_dir     (p2_dir),
    .start_pulse(start_pulse),
    .esc_pulse  (esc_pulse),
    .last_code  (last_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_pulse) n_start++;
    if (esc_pulse) n_esc++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    scan_valid = 1'b0;
    move_tick  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Returns at the negedge right after the capturing edge.
  task automatic send_t(input logic [7:0] b, input logic t);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    move_tick  = t;
    @(negedge clk);
    scan_valid = 1'b0;
    move_tick  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_t(b, 1'b0);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    n_start    = 0;
    n_esc      = 0;
    reset_n    = 1'b1;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    move_tick  = 1'b0;
    game_idle  = 1'b0;

    do_reset();
    check("rst_p1", p1_dir, 2'b01);
    check("rst_p2", p2_dir, 2'b11);
    check("rst_start", start_pulse, 1'b0);
    check("rst_esc", esc_pulse, 1'b0);
    check("rst_last", last_code, 8'h00);

    // Latency: no change before the capturing edge.
    scan_code  = 8'h1D;
    scan_valid = 1'b1;
    #1;
    check("lat_pre", p1_dir, 2'b01);
    @(negedge clk);
    scan_valid = 1'b0;
    check("w_up", p1_dir, 2'b00);
    check("w_last", last_code, 8'h1D);
    check("w_p2", p2_dir, 2'b11);

    send(8'hF0);
    send(8'h23);
    check("brk_nolast", last_code, 8'h1D);
    check("brk_nosteer", p1_dir, 2'b00);

    send(8'hE0);
    send(8'h74);
    check("p2_rev", p2_dir, 2'b11);
    check("p2_rev_last", last_code, 8'h74);
    send(8'hE0);
    send(8'h75);
    check("p2_up", p2_dir, 2'b00);
    send(8'h72);
    check("kp_nosteer", p2_dir, 2'b00);
    check("kp_last", last_code, 8'h72);

    // Back-to-back bytes.
    @(negedge clk);
    scan_code  = 8'hE0;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_code = 8'h72;
    @(negedge clk);
    scan_valid = 1'b0;
    check("b2b_down", p2_dir, 2'b10);

    base = n_start;
    send(8'h29);
    check("spc_pulse", start_pulse, 1'b1);
    @(negedge clk);
    check("spc_width", start_pulse, 1'b0);
    send(8'h29);
    send(8'h29);
    send(8'hF0);
    send(8'h29);
    check("spc_brk", start_pulse, 1'b0);
    send(8'h29);
    @(negedge clk);
    check("spc_count", n_start - base, 2);

    base = n_esc;
    send(8'h76);
    check("esc_pulse", esc_pulse, 1'b1);
    send(8'h76);
    send(8'hF0);
    send(8'h76);
    send(8'h76);
    @(negedge clk);
    check("esc_count", n_esc - base, 2);

    do_reset();
    send(8'h1D);
    send(8'h1C);
    check("rev_reject", p1_dir, 2'b00);

    do_reset();
    send(8'h1D);
    send_t(8'h1C, 1'b1);
    check("race_left", p1_dir, 2'b11);
    send(8'h23);
    check("after_right", p1_dir, 2'b01);
    send(8'h1B);
    check("moved_up_rej", p1_dir, 2'b01);

    do_reset();
    send(8'hE0);
    repeat (1010) @(negedge clk);
    send(8'h1B);
    check("to_down", p1_dir, 2'b10);
    check("to_last", last_code, 8'h1B);

    do_reset();
    send(8'hE0);
    repeat (500) @(negedge clk);
    send(8'h1B);
    check("ext_ignored", p1_dir, 2'b01);
    check("ext_last", last_code, 8'h1B);
    send(8'h1D);
    check("ext_idle", p1_dir, 2'b00);

    do_reset();
    @(negedge clk);
    game_idle = 1'b1;
    send(8'h1D);
    check("gi_p1", p1_dir, 2'b01);
    send(8'h29);
    check("gi_start", start_pulse, 1'b1);
    send(8'hE0);
    send(8'h75);
    check("gi_p2", p2_dir, 2'b11);
    check("gi_last", last_code, 8'h75);
    @(negedge clk);
    game_idle = 1'b0;
    send(8'h1B);
    check("gi_off", p1_dir, 2'b10);

    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h1D);
    check("rst_brk_p1", p1_dir, 2'b00);
    check("rst_brk_last", last_code, 8'h1D);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
